// File: rtl/store_queue_fwd.sv
// store_queue_fwd: circular store queue draining to the dcache, with byte-wise load forwarding
module store_queue_fwd #(
    parameter int SQ_SZ = 8,
    parameter int PTR_W = $clog2(SQ_SZ) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sq_alloc_valid_i,
    output logic             sq_full_o,
    output logic [PTR_W-1:0] sq_alloc_tail_o,
    input  logic             st_exec_valid_i,
    input  logic [PTR_W-1:0] st_exec_idx_i,
    input  logic [31:0]      st_exec_addr_i,
    input  logic [31:0]      st_exec_data_i,
    input  logic [1:0]       st_exec_size_i,
    input  logic             st_retire_valid_i,
    input  logic             b_mm_mispred_i,
    input  logic [PTR_W-1:0] sq_restore_tail_i,
    output logic             st_cache_req_valid_o,
    output logic [31:0]      st_cache_addr_o,
    output logic [31:0]      st_cache_data_o,
    output logic [3:0]       st_cache_mask_o,
    input  logic             st_cache_gnt_i,
    input  logic [PTR_W-1:0] load_sq_tail_i,
    input  logic [31:0]      load_req_addr_i,
    output logic [31:0]      sq_load_data_o,
    output logic [3:0]       sq_data_mask_o,
    output logic             sq_load_stall_o
);
    localparam int IDX_W = PTR_W - 1;
    typedef enum logic [1:0] {EMPTY, ALLOC, EXEC, COMMIT} st_e;
    st_e              st_q [SQ_SZ];
    st_e              st_d [SQ_SZ];
    logic [29:0]      addr_q [SQ_SZ];
    logic [29:0]      addr_d [SQ_SZ];
    logic [31:0]      data_q [SQ_SZ];
    logic [31:0]      data_d [SQ_SZ];
    logic [3:0]       mask_q [SQ_SZ];
    logic [3:0]       mask_d [SQ_SZ];
    logic [PTR_W-1:0] head_q, head_d, commit_q, commit_d, tail_q, tail_d;
    logic [IDX_W-1:0] head_idx, commit_idx, tail_idx, exec_idx, restore_idx, slot;
    logic [PTR_W-1:0] squash_n, load_n;
    logic [SQ_SZ-1:0] squash;
    logic [3:0]       exec_mask;
    logic [31:0]      exec_data;
    logic             req, exec_ok, unused;
    assign head_idx    = head_q[IDX_W-1:0];
    assign commit_idx  = commit_q[IDX_W-1:0];
    assign tail_idx    = tail_q[IDX_W-1:0];
    assign exec_idx    = st_exec_idx_i[IDX_W-1:0];
    assign restore_idx = sq_restore_tail_i[IDX_W-1:0];
    assign squash_n    = tail_q - sq_restore_tail_i;
    assign load_n      = load_sq_tail_i - head_q;
    assign unused      = ^{load_req_addr_i[1:0], st_exec_idx_i[PTR_W-1]};
    assign sq_full_o       = (tail_q - head_q) == PTR_W'(SQ_SZ);
    assign sq_alloc_tail_o = tail_q;
    assign req                  = st_q[head_idx] == COMMIT;
    assign st_cache_req_valid_o = req;
    assign st_cache_addr_o      = req ? {addr_q[head_idx], 2'b00} : '0;
    assign st_cache_data_o      = req ? data_q[head_idx] : '0;
    assign st_cache_mask_o      = req ? mask_q[head_idx] : '0;
    assign exec_mask = st_exec_size_i == 2'd0 ? 4'b0001 << st_exec_addr_i[1:0] :
                       st_exec_size_i == 2'd1 ? 4'b0011 << st_exec_addr_i[1:0] : 4'hF;
    assign exec_data = st_exec_data_i << {st_exec_addr_i[1:0], 3'b000};
    // Slots in [restore, old tail) measured as distance from the restore point
    always_comb begin
        squash = '0;
        for (int i = 0; i < SQ_SZ; i++)
            squash[i] = {1'b0, IDX_W'(IDX_W'(i) - restore_idx)} < squash_n;
    end
    assign exec_ok = st_exec_valid_i && !(b_mm_mispred_i && squash[exec_idx]);
    always_comb begin
        st_d     = st_q;
        addr_d   = addr_q;
        data_d   = data_q;
        mask_d   = mask_q;
        head_d   = head_q;
        commit_d = commit_q;
        tail_d   = tail_q;
        if (exec_ok) begin
            st_d[exec_idx]   = EXEC;
            addr_d[exec_idx] = st_exec_addr_i[31:2];
            data_d[exec_idx] = exec_data;
            mask_d[exec_idx] = exec_mask;
        end
        if (st_retire_valid_i && st_q[commit_idx] == EXEC) begin
            st_d[commit_idx] = COMMIT;
            commit_d         = commit_q + 1'b1;
        end
        if (req && st_cache_gnt_i) begin
            st_d[head_idx] = EMPTY;
            head_d         = head_q + 1'b1;
        end
        if (b_mm_mispred_i) begin
            tail_d = sq_restore_tail_i;
            for (int i = 0; i < SQ_SZ; i++)
                if (squash[i]) st_d[i] = EMPTY;
        end else if (sq_alloc_valid_i && !sq_full_o) begin
            st_d[tail_idx] = ALLOC;
            tail_d         = tail_q + 1'b1;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= '0;
            for (int i = 0; i < SQ_SZ; i++) begin
                st_q[i]   <= EMPTY;
                addr_q[i] <= '0;
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            head_q   <= head_d;
            commit_q <= commit_d;
            tail_q   <= tail_d;
            st_q     <= st_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
        end
    end
    // Walk candidates oldest to youngest so the youngest matching store wins each lane
    always_comb begin
        sq_load_data_o  = '0;
        sq_data_mask_o  = '0;
        sq_load_stall_o = 1'b0;
        slot            = '0;
        for (int k = 0; k < SQ_SZ; k++) begin
            slot = head_idx + IDX_W'(k);
            if (PTR_W'(k) < load_n) begin
                if (st_q[slot] == ALLOC) sq_load_stall_o = 1'b1;
                if ((st_q[slot] == EXEC || st_q[slot] == COMMIT) && addr_q[slot] == load_req_addr_i[31:2])
                    for (int b = 0; b < 4; b++)
                        if (mask_q[slot][b]) begin
                            sq_load_data_o[8*b +: 8] = data_q[slot][8*b +: 8];
                            sq_data_mask_o[b]        = 1'b1;
                        end
            end
        end
    end
endmodule

// File: tb/tb_store_queue_fwd.sv
// tb_store_queue_fwd: directed checks of allocation, drain, forwarding, mispredict and reset
module tb_store_queue_fwd;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        sq_alloc_valid_i, st_exec_valid_i, st_retire_valid_i, b_mm_mispred_i, st_cache_gnt_i;
    logic [3:0]  st_exec_idx_i, sq_restore_tail_i, load_sq_tail_i;
    logic [31:0] st_exec_addr_i, st_exec_data_i, load_req_addr_i;
    logic [1:0]  st_exec_size_i;
    logic        sq_full_o, st_cache_req_valid_o, sq_load_stall_o;
    logic [3:0]  sq_alloc_tail_o, st_cache_mask_o, sq_data_mask_o;
    logic [31:0] st_cache_addr_o, st_cache_data_o, sq_load_data_o;
    int checks = 0;
    int errors = 0;
    store_queue_fwd dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .sq_alloc_valid_i(sq_alloc_valid_i), .sq_full_o(sq_full_o), .sq_alloc_tail_o(sq_alloc_tail_o),
        .st_exec_valid_i(st_exec_valid_i), .st_exec_idx_i(st_exec_idx_i), .st_exec_addr_i(st_exec_addr_i),
        .st_exec_data_i(st_exec_data_i), .st_exec_size_i(st_exec_size_i),
        .st_retire_valid_i(st_retire_valid_i), .b_mm_mispred_i(b_mm_mispred_i),
        .sq_restore_tail_i(sq_restore_tail_i),
        .st_cache_req_valid_o(st_cache_req_valid_o), .st_cache_addr_o(st_cache_addr_o),
        .st_cache_data_o(st_cache_data_o), .st_cache_mask_o(st_cache_mask_o), .st_cache_gnt_i(st_cache_gnt_i),
        .load_sq_tail_i(load_sq_tail_i), .load_req_addr_i(load_req_addr_i),
        .sq_load_data_o(sq_load_data_o), .sq_data_mask_o(sq_data_mask_o), .sq_load_stall_o(sq_load_stall_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk_i);
        #1;
        sq_alloc_valid_i = 0; st_exec_valid_i = 0; st_retire_valid_i = 0;
        b_mm_mispred_i = 0; st_cache_gnt_i = 0;
    endtask
    task automatic exec(input logic [3:0] idx, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        st_exec_valid_i = 1; st_exec_idx_i = idx; st_exec_addr_i = a; st_exec_data_i = d; st_exec_size_i = sz;
        cyc();
    endtask
    task automatic fwd(input string tag, input logic [3:0] t, input logic [31:0] a,
                       input logic [31:0] ed, input logic [3:0] em, input logic es);
        load_sq_tail_i = t; load_req_addr_i = a;
        #1;
        chk({tag, ".data"}, sq_load_data_o, ed);
        chk({tag, ".mask"}, 32'(sq_data_mask_o), 32'(em));
        chk({tag, ".stall"}, 32'(sq_load_stall_o), 32'(es));
    endtask
    initial begin
        rst_ni = 0;
        sq_alloc_valid_i = 0; st_exec_valid_i = 0; st_retire_valid_i = 0; b_mm_mispred_i = 0; st_cache_gnt_i = 0;
        st_exec_idx_i = 0; st_exec_addr_i = 0; st_exec_data_i = 0; st_exec_size_i = 0;
        sq_restore_tail_i = 0; load_sq_tail_i = 0; load_req_addr_i = 0;
        #1;
        chk("rst.full", 32'(sq_full_o), 0);
        chk("rst.tail", 32'(sq_alloc_tail_o), 0);
        chk("rst.req", 32'(st_cache_req_valid_o), 0);
        chk("rst.cmask", 32'(st_cache_mask_o), 0);
        cyc(); cyc();
        rst_ni = 1;
        // Fill to full, then one refused allocate
        for (int i = 0; i < 8; i++) begin
            chk("fill.tail", 32'(sq_alloc_tail_o), 32'(i));
            chk("fill.notfull", 32'(sq_full_o), 0);
            sq_alloc_valid_i = 1;
            cyc();
        end
        chk("fill.full", 32'(sq_full_o), 1);
        chk("fill.tail8", 32'(sq_alloc_tail_o), 8);
        $display("note: issuing sq_alloc_valid while full (protocol error), expect it ignored");
        sq_alloc_valid_i = 1;
        cyc();
        chk("over.tail", 32'(sq_alloc_tail_o), 8);
        chk("over.full", 32'(sq_full_o), 1);
        for (int i = 0; i < 8; i++) exec(4'(i), 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 2'd2);
        for (int i = 0; i < 8; i++) begin
            st_retire_valid_i = 1;
            cyc();
        end
        chk("drain.req", 32'(st_cache_req_valid_o), 1);
        chk("drain.mask", 32'(st_cache_mask_o), 32'hF);
        for (int i = 0; i < 8; i++) begin
            chk("drain.addr", st_cache_addr_o, 32'h100 + 32'(4 * i));
            chk("drain.data", st_cache_data_o, 32'hA0 + 32'(i));
            st_cache_gnt_i = 1;
            cyc();
        end
        chk("empty.req", 32'(st_cache_req_valid_o), 0);
        chk("empty.full", 32'(sq_full_o), 0);
        chk("empty.tail", 32'(sq_alloc_tail_o), 8);
        // Byte forwarding priority, pointers now at 8 (wrap set, index 0)
        sq_alloc_valid_i = 1; cyc();
        sq_alloc_valid_i = 1; cyc();
        exec(4'd8, 32'h1000, 32'hAABBCCDD, 2'd2);
        exec(4'd9, 32'h1001, 32'h11, 2'd0);
        fwd("fwd.both", 4'd10, 32'h1000, 32'hAABB11DD, 4'hF, 0);
        fwd("fwd.old", 4'd9, 32'h1003, 32'hAABBCCDD, 4'hF, 0);
        fwd("fwd.none", 4'd8, 32'h1000, 0, 0, 0);
        fwd("fwd.miss", 4'd10, 32'h1004, 0, 0, 0);
        st_retire_valid_i = 1; cyc();
        st_retire_valid_i = 1; cyc();
        st_cache_gnt_i = 1; cyc();
        st_cache_gnt_i = 1; cyc();
        chk("fwd.drained", 32'(st_cache_req_valid_o), 0);
        // Unresolved older store stalls the load
        sq_alloc_valid_i = 1; cyc();
        fwd("stall.on", 4'd11, 32'h3000, 0, 0, 1);
        exec(4'd10, 32'h4000, 32'h5, 2'd2);
        fwd("stall.off", 4'd11, 32'h3000, 0, 0, 0);
        st_retire_valid_i = 1; cyc();
        chk("pre_rst.req", 32'(st_cache_req_valid_o), 1);
        fwd("pre_rst.fwd", 4'd11, 32'h4000, 32'h5, 4'hF, 0);
        // Asynchronous reset mid-cycle while a write is pending
        #2;
        rst_ni = 0;
        #1;
        chk("arst.req", 32'(st_cache_req_valid_o), 0);
        chk("arst.cmask", 32'(st_cache_mask_o), 0);
        chk("arst.ldata", sq_load_data_o, 0);
        chk("arst.lmask", 32'(sq_data_mask_o), 0);
        chk("arst.stall", 32'(sq_load_stall_o), 0);
        chk("arst.tail", 32'(sq_alloc_tail_o), 0);
        chk("arst.full", 32'(sq_full_o), 0);
        cyc();
        rst_ni = 1;
        load_sq_tail_i = 0;
        #1;
        chk("post_rst.tail", 32'(sq_alloc_tail_o), 0);
        chk("post_rst.req", 32'(st_cache_req_valid_o), 0);
        // Mispredict with a same-cycle allocate and an execute to a squashed slot
        for (int i = 0; i < 5; i++) begin
            sq_alloc_valid_i = 1;
            cyc();
        end
        exec(4'd0, 32'h500, 32'h50, 2'd2);
        exec(4'd1, 32'h504, 32'h51, 2'd2);
        exec(4'd2, 32'h700, 32'h52, 2'd2);
        exec(4'd3, 32'h600, 32'h77, 2'd2);
        st_retire_valid_i = 1; cyc();
        st_retire_valid_i = 1; cyc();
        b_mm_mispred_i = 1; sq_restore_tail_i = 4'd3; sq_alloc_valid_i = 1;
        st_exec_valid_i = 1; st_exec_idx_i = 4'd4; st_exec_addr_i = 32'h600; st_exec_data_i = 32'h99; st_exec_size_i = 2'd2;
        cyc();
        chk("mp.tail", 32'(sq_alloc_tail_o), 3);
        fwd("mp.squashed", 4'd5, 32'h600, 0, 0, 0);
        fwd("mp.commit_fwd", 4'd3, 32'h500, 32'h50, 4'hF, 0);
        chk("mp.req", 32'(st_cache_req_valid_o), 1);
        chk("mp.addr0", st_cache_addr_o, 32'h500);
        chk("mp.data0", st_cache_data_o, 32'h50);
        st_cache_gnt_i = 1; cyc();
        chk("mp.addr1", st_cache_addr_o, 32'h504);
        chk("mp.data1", st_cache_data_o, 32'h51);
        st_cache_gnt_i = 1; cyc();
        chk("mp.idle", 32'(st_cache_req_valid_o), 0);
        st_retire_valid_i = 1; cyc();
        st_cache_gnt_i = 1; cyc();
        chk("mp.empty", 32'(st_cache_req_valid_o), 0);
        // Committed-but-undrained half at index 7 with the tail wrapped
        for (int i = 0; i < 6; i++) begin
            sq_alloc_valid_i = 1;
            cyc();
        end
        chk("wrap.tail", 32'(sq_alloc_tail_o), 9);
        exec(4'd3, 32'h800, 32'h1, 2'd2);
        exec(4'd4, 32'h804, 32'h2, 2'd2);
        exec(4'd5, 32'h808, 32'h3, 2'd2);
        exec(4'd6, 32'h80C, 32'h4, 2'd2);
        exec(4'd7, 32'h2002, 32'hBEEF, 2'd1);
        for (int i = 0; i < 5; i++) begin
            st_retire_valid_i = 1;
            cyc();
        end
        fwd("wrap.half", 4'd8, 32'h2000, 32'hBEEF0000, 4'b1100, 0);
        fwd("wrap.stall", 4'd9, 32'h2000, 32'hBEEF0000, 4'b1100, 1);
        chk("wrap.req", 32'(st_cache_req_valid_o), 1);
        chk("wrap.addr", st_cache_addr_o, 32'h800);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_queue_fwd.md
Name: store_queue_fwd

Overview:
- Circular store queue for the out-of-order RISC-V core.
- Holds stores from dispatch until execute, retire and drain to the data cache.
- Acts as the responder on the load-forwarding interface. Given a load's SQ tail snapshot and word address, it returns forwarded bytes, a byte-valid mask, and a stall flag when an older store address is unresolved.
- Sits between dispatch/execute/retire and the data cache write port.

Parameters:
- SQ_SZ, 8, number of entries; power of two, at least 2.
- PTR_W, $clog2(SQ_SZ)+1, pointer width; the MSB is the wrap bit.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- sq_alloc_valid  in  1  dispatch allocates a store at the tail
- sq_full  out  1  count == SQ_SZ
- sq_alloc_tail  out  PTR_W  current tail; the store records this as its SQ index
- st_exec_valid  in  1  store address and data resolved
- st_exec_idx  in  PTR_W  entry written by execute
- st_exec_addr  in  32  byte address
- st_exec_data  in  32  store data, right-aligned
- st_exec_size  in  2  0 = byte, 1 = half, 2 = word
- st_retire_valid  in  1  ROB retires the oldest uncommitted store
- b_mm_mispred  in  1  branch mispredict
- sq_restore_tail  in  PTR_W  tail checkpoint to restore on mispredict
- st_cache_req_valid  out  1  head entry committed, write request asserted
- st_cache_addr  out  32  word-aligned address
- st_cache_data  out  32  lane-aligned data
- st_cache_mask  out  4  byte enables
- st_cache_gnt  in  1  cache accepts the write this cycle
- load_sq_tail  in  PTR_W  load's tail snapshot; entries older than it are checked
- load_req_addr  in  32  load address, compared on bits [31:2]
- sq_load_data  out  32  forwarded bytes in their lanes
- sq_data_mask  out  4  forwarded byte lanes
- sq_load_stall  out  1  an older store in range has an unresolved address

Behaviour:
- Entry state per slot: EMPTY -> ALLOC (on dispatch) -> EXEC (on execute) -> COMMIT (on retire) -> EMPTY (on cache grant).
- Pointers: head (drain), commit (next to retire), tail (next to allocate). All PTR_W wide.
  - Index = ptr[PTR_W-2:0]. Wrap bit toggles when the index passes SQ_SZ-1.
  - count = tail - head, modulo 2^PTR_W.
- Reset (asynchronous, reset=0):
  - All entries go EMPTY; head = commit = tail = 0.
  - sq_full=0, st_cache_req_valid=0, st_cache_mask=0, sq_load_data=0, sq_data_mask=0, sq_load_stall=0, sq_alloc_tail=0.
  - A reset mid-drain drops the pending write with no grant required.
- Allocate:
  - Takes effect when sq_alloc_valid && !sq_full. Entry[tail] becomes ALLOC; tail increments at the clock edge.
  - sq_alloc_valid while full is ignored (a protocol error; the bench flags it).
- Execute:
  - Writes addr, data and size into entry[st_exec_idx]; state becomes EXEC at the edge.
  - Byte mask: byte -> 1<<a[1:0]; half -> 3<<a[1:0]; word -> 4'hF. Data is shifted left by 8*a[1:0].
  - Misaligned halves/words are not supported; the mask is truncated to 4 bits.
- Retire:
  - entry[commit] must be EXEC. State becomes COMMIT and commit increments.
  - Retiring an entry that is not EXEC is a protocol error; the state is left unchanged.
- Drain:
  - st_cache_req_valid = (entry[head] == COMMIT), driven from registered state only.
  - On st_cache_gnt with a valid request: entry[head] goes EMPTY and head increments. st_cache_gnt without a request is ignored.
  - Request fields hold stable until granted.
- Mispredict:
  - On b_mm_mispred: tail <- sq_restore_tail, and entries in [sq_restore_tail, old tail) go EMPTY.
  - Restore never crosses commit; committed and EXEC entries older than the restore point survive.
  - Mispredict has priority over allocate in the same cycle (the allocate is dropped).
  - A same-cycle execute to a squashed index is dropped.
  - Retire and drain proceed normally in the same cycle.
- Simultaneous events:
  - Allocate and drain in one cycle: both apply; sq_full is from pre-edge state, so a full queue refuses the allocate even when draining.
  - Retire and drain of the same entry cannot coincide (drain needs COMMIT already registered).
- Forwarding (combinational, same cycle as the load request):
  - Candidate entries are indices from head up to, but excluding, load_sq_tail. This includes COMMIT entries not yet drained.
  - Per byte lane, the youngest candidate in EXEC or COMMIT with a matching addr[31:2] and its lane-mask bit set supplies that byte and sets its sq_data_mask bit.
  - sq_load_stall=1 if any candidate is ALLOC, i.e. its address is unknown.
  - load_sq_tail == head means no candidates: mask=0, data=0, stall=0.
  - Bytes outside the mask read as 0.
- sq_full and sq_alloc_tail are derived from registered pointers only (no combinational path from inputs).

Test Plan:
- Fill and drain:
  - 8 allocates -> sq_full=1 after the 8th edge; a 9th sq_alloc_valid leaves tail=8 (wrap bit set, index 0).
  - Execute, retire and grant all 8 -> head returns to tail, count=0.
- Byte forwarding priority:
  - Stores, oldest first: word 0x1000 = 0xAABBCCDD, then byte 0x1001 = 0x11, both executed.
  - Load addr 0x1000 with tail snapshot past both -> sq_load_data=0xAABB11DD, sq_data_mask=4'hF.
- Unresolved older store:
  - Allocate store A (no execute), then take a load snapshot.
  - -> sq_load_stall=1. After A executes at a non-matching address -> stall=0, mask=0.
- Mispredict:
  - Allocate 5 stores, retire 2, then mispredict with restore=3 in the same cycle as an allocate.
  - -> tail=3; entries 3-4 EMPTY; the allocate is dropped; committed entries 0-1 still drain.
- Committed-not-drained forwarding and wrap:
  - Hold st_cache_gnt=0 with committed half 0x2002 = 0xBEEF at index 7 and tail wrapped.
  - Load 0x2000 -> sq_data_mask=4'b1100, sq_load_data=0xBEEF0000.
- Asynchronous reset:
  - Assert reset=0 mid-cycle while st_cache_req_valid=1.
  - -> all outputs 0 immediately, before the next clock edge; pointers 0 after reset is released.
